// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle controller and its datapath.
// Holds the FSM state codes, opcode/funct constants, the mux/ALU select
// codes and the control-strobe bundle driven by mc_decode.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXE_R   = 4'd2,
        ST_EXE_I   = 4'd3,
        ST_MEM_ADR = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_MEM_WR  = 4'd6,
        ST_WB_ALU  = 4'd7,
        ST_WB_MEM  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_LUI  = 4'd3;

    localparam logic [1:0] WA_RT    = 2'd0;
    localparam logic [1:0] WA_RD    = 2'd1;
    localparam logic [1:0] WA_RA    = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MEM   = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_J    = 2'd2;
    localparam logic [1:0] NPC_JR   = 2'd3;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic [1:0] wa_sel;
        logic [1:0] wd_sel;
        logic [1:0] npc_sel;
        logic       ext_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
    } ctrl_t;

    // State entered after DECODE; unknown opcodes/functs fall back to FETCH.
    function automatic state_e decode_target(input logic [5:0] op, input logic [5:0] funct);
        state_e nxt;
        nxt = ST_FETCH;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) nxt = ST_EXE_R;
                else if (funct == FN_JR)                  nxt = ST_JUMP;
            end
            OP_ORI, OP_LUI: nxt = ST_EXE_I;
            OP_LW, OP_SW:   nxt = ST_MEM_ADR;
            OP_BEQ:         nxt = ST_BRANCH;
            OP_J, OP_JAL:   nxt = ST_JUMP;
            default:        nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational map from {state, op, funct, zero} to the datapath
// strobes. mem_ready only qualifies the FETCH-completion strobes.
// Ports:
//   state     in  current FSM state (codes 11-15 decode to all-zero strobes)
//   op, funct in  instruction opcode / funct fields
//   zero      in  ALU equality flag (used in BRANCH)
//   mem_ready in  memory handshake, already gated off while in reset
//   ctrl      out strobe bundle
module mc_decode
    import mc_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [3:0]       state,
    input  logic [OPC_W-1:0] op,
    input  logic [OPC_W-1:0] funct,
    input  logic             zero,
    input  logic             mem_ready,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.npc_sel   = NPC_PC4;
                // IR and PC load only on the cycle the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_EXE_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            ST_EXE_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (op == OP_LUI) ? ALU_LUI : ALU_OR;
            end
            ST_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.wd_sel    = WD_ALU;
                ctrl.wa_sel    = (op == OP_RTYPE) ? WA_RD : WA_RT;
            end
            ST_WB_MEM: begin
                ctrl.reg_write = 1'b1;
                ctrl.wd_sel    = WD_MEM;
                ctrl.wa_sel    = WA_RT;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.npc_sel   = NPC_BR;
                ctrl.pc_write  = zero;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.npc_sel  = (op == OP_RTYPE && funct == FN_JR) ? NPC_JR : NPC_J;
                // jal links the already-incremented PC into $31.
                if (op == OP_JAL) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.wa_sel    = WA_RA;
                    ctrl.wd_sel    = WD_PC;
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset controller. Holds the FSM state and the
// retired-instruction counter; strobes come from mc_decode.
// Ports:
//   Clock, Reset (async, active-low)
//   Op, Function   instruction fields, stable from DECODE until FETCH
//   Zero           ALU equality result; MemReady memory completion
//   PcWrite IrWrite RegWrite MemRead MemWrite IorD WaSel WdSel nPc_Sel
//   ExtOp AluSrcA AluSrcB AluOp  datapath controls
//   State          current state (debug); InstrCount retired instructions
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [OPC_W-1:0] Op,
    input  logic [OPC_W-1:0] Function,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PcWrite,
    output logic             IrWrite,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic [1:0]       WaSel,
    output logic [1:0]       WdSel,
    output logic [1:0]       nPc_Sel,
    output logic             ExtOp,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [3:0]       AluOp,
    output logic [3:0]       State,
    output logic [31:0]      InstrCount
);

    logic [3:0]  state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        retire;
    ctrl_t       ctrl;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH:   if (MemReady) state_d = ST_DECODE;
            ST_DECODE:  state_d = decode_target(Op, Function);
            ST_EXE_R,
            ST_EXE_I:   state_d = ST_WB_ALU;
            ST_MEM_ADR: state_d = (Op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  if (MemReady) state_d = ST_WB_MEM;
            ST_MEM_WR: begin
                if (MemReady) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = ST_FETCH;
        endcase
        count_d = retire ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Masking MemReady during reset keeps the FETCH write strobes quiet
    // while the reset that aborted an instruction is still held.
    mc_decode #(.OPC_W(OPC_W)) u_decode (
        .state     (state_q),
        .op        (Op),
        .funct     (Function),
        .zero      (Zero),
        .mem_ready (MemReady & Reset),
        .ctrl      (ctrl)
    );

    assign PcWrite    = ctrl.pc_write;
    assign IrWrite    = ctrl.ir_write;
    assign RegWrite   = ctrl.reg_write;
    assign MemRead    = ctrl.mem_read;
    assign MemWrite   = ctrl.mem_write;
    assign IorD       = ctrl.iord;
    assign WaSel      = ctrl.wa_sel;
    assign WdSel      = ctrl.wd_sel;
    assign nPc_Sel    = ctrl.npc_sel;
    assign ExtOp      = ctrl.ext_op;
    assign AluSrcA    = ctrl.alu_src_a;
    assign AluSrcB    = ctrl.alu_src_b;
    assign AluOp      = ctrl.alu_op;
    assign State      = state_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction stream against a per-instruction
// reference model that expands each instruction class into its expected
// cycle-by-cycle states and strobes.
module tb_mc_ctrl;

    logic        Clock, Reset, Zero, MemReady;
    logic [5:0]  Op, Function;
    logic        PcWrite, IrWrite, RegWrite, MemRead, MemWrite, IorD, ExtOp, AluSrcA;
    logic [1:0]  WaSel, WdSel, nPc_Sel, AluSrcB;
    logic [3:0]  AluOp, State;
    logic [31:0] InstrCount;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mr, mw, iord;
        logic [1:0] wa, wd, npc;
        logic       ext, srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
    } exp_t;

    exp_t obs;
    assign obs = {State, PcWrite, IrWrite, RegWrite, MemRead, MemWrite, IorD,
                  WaSel, WdSel, nPc_Sel, ExtOp, AluSrcA, AluSrcB, AluOp};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_cnt = 0;

    mc_ctrl #(.OPC_W(6)) dut (
        .Clock(Clock), .Reset(Reset), .Op(Op), .Function(Function),
        .Zero(Zero), .MemReady(MemReady),
        .PcWrite(PcWrite), .IrWrite(IrWrite), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .WaSel(WaSel), .WdSel(WdSel), .nPc_Sel(nPc_Sel),
        .ExtOp(ExtOp), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
        .State(State), .InstrCount(InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t fetch_e(input logic done);
        exp_t e;
        e = mk(4'd0);
        e.mr = 1'b1;
        e.srcb = 2'd1;
        e.pcw = done;
        e.irw = done;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive, let combinational outputs settle, compare, advance.
    task automatic cycle(input logic rdy, input logic z, input exp_t e, input string tag);
        MemReady = rdy;
        Zero     = z;
        #1;
        check_eq(tag, 64'(obs), 64'(e));
        check_eq({tag, "_cnt"}, 64'(InstrCount), 64'(model_cnt));
        @(posedge Clock);
        #1;
    endtask

    // kinds: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 jal 9 jr
    //        10 undefined opcode 11 R-type with undefined funct
    task automatic run_instr(input int kind, input int fw, input int mwait, input logic z);
        logic [5:0] op, fn;
        exp_t       e;
        bit         retires;
        retires = 1'b1;
        fn = 6'($urandom);
        case (kind)
            0:  begin op = 6'b000000; fn = 6'b100001; end
            1:  begin op = 6'b000000; fn = 6'b100011; end
            2:  op = 6'b001101;
            3:  op = 6'b001111;
            4:  op = 6'b100011;
            5:  op = 6'b101011;
            6:  op = 6'b000100;
            7:  op = 6'b000010;
            8:  op = 6'b000011;
            9:  begin op = 6'b000000; fn = 6'b001000; end
            10: begin
                do op = 6'($urandom);
                while (op inside {6'b000000, 6'b001101, 6'b001111, 6'b100011,
                                  6'b101011, 6'b000100, 6'b000010, 6'b000011});
            end
            default: begin
                op = 6'b000000;
                do fn = 6'($urandom);
                while (fn inside {6'b100001, 6'b100011, 6'b001000});
            end
        endcase
        Op = op;
        Function = fn;

        for (int i = 0; i < fw; i++) cycle(1'b0, rbit(), fetch_e(1'b0), "FETCH_WAIT");
        cycle(1'b1, rbit(), fetch_e(1'b1), "FETCH");
        cycle(rbit(), rbit(), mk(4'd1), "DECODE");

        case (kind)
            0, 1: begin
                e = mk(4'd2); e.srca = 1'b1; e.aluop = (kind == 1) ? 4'd1 : 4'd0;
                cycle(rbit(), rbit(), e, "EXE_R");
                e = mk(4'd7); e.rw = 1'b1; e.wa = 2'd1;
                cycle(rbit(), rbit(), e, "WB_ALU_R");
            end
            2, 3: begin
                e = mk(4'd3); e.srca = 1'b1; e.srcb = 2'd2; e.aluop = (kind == 3) ? 4'd3 : 4'd2;
                cycle(rbit(), rbit(), e, "EXE_I");
                e = mk(4'd7); e.rw = 1'b1;
                cycle(rbit(), rbit(), e, "WB_ALU_I");
            end
            4, 5: begin
                e = mk(4'd4); e.srca = 1'b1; e.srcb = 2'd2; e.ext = 1'b1;
                cycle(rbit(), rbit(), e, "MEM_ADR");
                e = (kind == 4) ? mk(4'd5) : mk(4'd6);
                e.iord = 1'b1;
                if (kind == 4) e.mr = 1'b1; else e.mw = 1'b1;
                for (int i = 0; i < mwait; i++) cycle(1'b0, rbit(), e, "MEM_WAIT");
                cycle(1'b1, rbit(), e, "MEM_DONE");
                if (kind == 4) begin
                    e = mk(4'd8); e.rw = 1'b1; e.wd = 2'd1;
                    cycle(rbit(), rbit(), e, "WB_MEM");
                end
            end
            6: begin
                e = mk(4'd9); e.srca = 1'b1; e.aluop = 4'd1; e.npc = 2'd1; e.pcw = z;
                cycle(rbit(), z, e, "BRANCH");
            end
            7, 8, 9: begin
                e = mk(4'd10); e.pcw = 1'b1; e.npc = (kind == 9) ? 2'd3 : 2'd2;
                if (kind == 8) begin e.rw = 1'b1; e.wa = 2'd2; e.wd = 2'd2; end
                cycle(rbit(), rbit(), e, "JUMP");
            end
            default: retires = 1'b0;
        endcase
        if (retires) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic reset_in_mem_wr();
        exp_t e;
        Op = 6'b101011;
        Function = 6'($urandom);
        cycle(1'b1, rbit(), fetch_e(1'b1), "RST_FETCH");
        cycle(rbit(), rbit(), mk(4'd1), "RST_DECODE");
        e = mk(4'd4); e.srca = 1'b1; e.srcb = 2'd2; e.ext = 1'b1;
        cycle(rbit(), rbit(), e, "RST_MEM_ADR");
        e = mk(4'd6); e.mw = 1'b1; e.iord = 1'b1;
        cycle(1'b0, rbit(), e, "RST_MEM_WR");
        // Still in MEM_WR here; pull reset between clock edges.
        MemReady = 1'b0;
        #2;
        Reset = 1'b0;
        model_cnt = 0;
        #1;
        check_eq("RST_ASYNC_STATE", 64'(obs), 64'(fetch_e(1'b0)));
        check_eq("RST_ASYNC_CNT", 64'(InstrCount), 64'd0);
        MemReady = 1'b1;
        #1;
        check_eq("RST_NO_STROBE", 64'(obs), 64'(fetch_e(1'b0)));
        @(posedge Clock);
        #1;
        check_eq("RST_HELD", 64'(obs), 64'(fetch_e(1'b0)));
        check_eq("RST_HELD_CNT", 64'(InstrCount), 64'd0);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        Op = '0;
        Function = '0;
        Zero = 1'b0;
        MemReady = 1'b0;
        #1;
        check_eq("RESET_STATE", 64'(obs), 64'(fetch_e(1'b0)));
        check_eq("RESET_CNT", 64'(InstrCount), 64'd0);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b1;

        // Directed openers: addu, lw with 3 wait cycles, beq both ways, jal, undefined op.
        run_instr(0, 0, 0, 1'b0);
        run_instr(4, 0, 3, 1'b0);
        run_instr(6, 0, 0, 1'b0);
        run_instr(6, 0, 0, 1'b1);
        run_instr(8, 0, 0, 1'b0);
        Op = 6'b111111;
        run_instr(10, 0, 0, 1'b0);

        for (int n = 0; n < 80; n++)
            run_instr(int'($urandom_range(0, 11)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), rbit());

        reset_in_mem_wr();

        for (int n = 0; n < 30; n++)
            run_instr(int'($urandom_range(0, 11)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), rbit());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
